// File: rtl/serial_frame_rx_if.sv
// Output port bundle of serial_frame_rx: received word with valid/ready
// handshake plus overrun and parity-error pulses.
//   pOut      : received word, stable while out_valid is high
//   out_valid : word available on pOut
//   out_ready : consumer accepts the word at a rising edge when valid
//   overrun   : one-cycle pulse, a completed word was dropped
//   frame_err : one-cycle pulse, parity mismatch, word discarded
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] pOut;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;
    logic              frame_err;

    modport master (
        output pOut,
        output out_valid,
        output overrun,
        output frame_err,
        input  out_ready
    );

    modport slave (
        input  pOut,
        input  out_valid,
        input  overrun,
        input  frame_err,
        output out_ready
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts sIn for START_PATTERN, then shifts in DATA_W
// payload bits MSB-first, optionally checks an even-parity bit.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   sIn       : serial data, sampled every rising edge
//   start_det : one-cycle pulse after the start pattern completes
//   busy      : high while receiving payload or parity
//   dout      : word output bundle (pOut/out_valid/out_ready/overrun/frame_err)
module serial_frame_rx #(
    parameter int                   START_LEN     = 4,
    parameter logic [START_LEN-1:0] START_PATTERN = 4'b0000,
    parameter int                   DATA_W        = 8,
    parameter int                   PARITY_EN     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sIn,
    output logic                  start_det,
    output logic                  busy,
    serial_frame_rx_if.master     dout
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        PARITY
    } state_t;

    state_t               state;
    // Only the low START_LEN-1 bits of the hunt window ever take part in
    // a match, so the oldest bit is not stored.
    logic [START_LEN-2:0] win;
    logic [CW-1:0]        cnt;
    logic [DATA_W-1:0]    shift;

    logic [START_LEN-1:0] wnext;
    logic [DATA_W-1:0]    snext;
    logic                 last;
    logic                 par_ok;
    logic                 fin;
    logic [DATA_W-1:0]    fin_word;

    assign wnext = {win, sIn};

    generate
        if (DATA_W == 1) begin : g_w1
            assign snext = sIn;
        end else begin : g_wn
            assign snext = {shift[DATA_W-2:0], sIn};
        end
    endgenerate

    assign last   = (cnt == CW'(DATA_W - 1));
    assign par_ok = ~(^shift ^ sIn);

    // A frame completes on the last data edge (no parity) or on a parity
    // edge whose parity bit makes the word even.
    assign fin = ((state == DATA) && last && (PARITY_EN == 0)) ||
                 ((state == PARITY) && par_ok);
    assign fin_word = (state == PARITY) ? shift : snext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= HUNT;
            win            <= ~START_PATTERN[START_LEN-2:0];
            cnt            <= '0;
            shift          <= '0;
            start_det      <= 1'b0;
            busy           <= 1'b0;
            dout.pOut      <= '0;
            dout.out_valid <= 1'b0;
            dout.overrun   <= 1'b0;
            dout.frame_err <= 1'b0;
        end else begin
            start_det      <= 1'b0;
            dout.overrun   <= 1'b0;
            dout.frame_err <= 1'b0;

            if (dout.out_valid && dout.out_ready) begin
                dout.out_valid <= 1'b0;
            end

            unique case (state)
                HUNT: begin
                    win <= wnext[START_LEN-2:0];
                    if (wnext == START_PATTERN) begin
                        state     <= DATA;
                        start_det <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        shift     <= '0;
                    end
                end
                DATA: begin
                    shift <= snext;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        if (PARITY_EN != 0) begin
                            state <= PARITY;
                        end else begin
                            state <= HUNT;
                            busy  <= 1'b0;
                            win   <= ~START_PATTERN[START_LEN-2:0];
                        end
                    end
                end
                PARITY: begin
                    state <= HUNT;
                    busy  <= 1'b0;
                    win   <= ~START_PATTERN[START_LEN-2:0];
                    if (!par_ok) begin
                        dout.frame_err <= 1'b1;
                    end
                end
                default: begin
                    state <= HUNT;
                    busy  <= 1'b0;
                    win   <= ~START_PATTERN[START_LEN-2:0];
                end
            endcase

            // Completion overrides the consume above, so a word landing on
            // the consume edge keeps out_valid high with no gap.
            if (fin) begin
                if (!dout.out_valid || dout.out_ready) begin
                    dout.pOut      <= fin_word;
                    dout.out_valid <= 1'b1;
                end else begin
                    dout.overrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Testbench for serial_frame_rx: directed tables, parity and wide-frame
// sequences, and randomized frames against a queue-based reference model.
module tb_serial_frame_rx;
    localparam int         L0 = 4;
    localparam int         W0 = 8;
    localparam logic [3:0] P0 = 4'b0000;

    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    logic sIn0, sIn1, sIn2;
    logic sd0, sd1, sd2;
    logic bz0, bz1, bz2;

    int total = 0;
    int bad   = 0;

    serial_frame_rx_if #(.DATA_W(8))  if0 ();
    serial_frame_rx_if #(.DATA_W(8))  if1 ();
    serial_frame_rx_if #(.DATA_W(12)) if2 ();

    serial_frame_rx u0 (
        .clk(clk), .rst(rst0), .sIn(sIn0),
        .start_det(sd0), .busy(bz0), .dout(if0)
    );

    serial_frame_rx #(.PARITY_EN(1)) u1 (
        .clk(clk), .rst(rst1), .sIn(sIn1),
        .start_det(sd1), .busy(bz1), .dout(if1)
    );

    serial_frame_rx #(
        .START_LEN(6), .START_PATTERN(6'b101100), .DATA_W(12)
    ) u2 (
        .clk(clk), .rst(rst2), .sIn(sIn2),
        .start_det(sd2), .busy(bz2), .dout(if2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Pulse / busy counters, sampled on the falling edge
    int st0 = 0, ov0 = 0, bc0 = 0, fe1 = 0, bc1 = 0;
    always @(negedge clk) begin
        if (sd0) st0++;
        if (if0.overrun) ov0++;
        if (bz0) bc0++;
        if (if1.frame_err) fe1++;
        if (bz1) bc1++;
    end

    // Reference model for u0: a queue holds the hunt window (reloaded with
    // the inverted pattern), another collects the payload bits.
    bit         hist[$];
    bit         pay[$];
    bit         hunting;
    logic [7:0] m_pout;
    bit         m_valid, m_start, m_busy, m_ovr;
    bit         v0, r0, b0, done, match;
    logic [7:0] w;

    task automatic reload();
        hist.delete();
        for (int i = 0; i < L0; i++) hist.push_back(~P0[L0-1-i]);
    endtask

    always @(posedge clk or negedge rst0) begin
        if (!rst0) begin
            reload();
            pay.delete();
            hunting = 1;
            m_pout  = '0;
            m_valid = 0;
            m_start = 0;
            m_busy  = 0;
            m_ovr   = 0;
        end else begin
            v0 = m_valid;
            r0 = if0.out_ready;
            b0 = sIn0;
            done = 0;
            m_start = 0;
            m_ovr = 0;
            if (hunting) begin
                hist.push_back(b0);
                void'(hist.pop_front());
                match = 1;
                for (int i = 0; i < L0; i++)
                    if (hist[i] != P0[L0-1-i]) match = 0;
                if (match) begin
                    hunting = 0;
                    pay.delete();
                    m_start = 1;
                end
            end else begin
                pay.push_back(b0);
                if (pay.size() == W0) begin
                    w = '0;
                    foreach (pay[i]) w = {w[6:0], pay[i]};
                    done = 1;
                    hunting = 1;
                    reload();
                end
            end
            if (v0 && r0) m_valid = 0;
            if (done) begin
                if (!v0 || r0) begin
                    m_pout  = w;
                    m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end
            m_busy = !hunting;
        end
    end

    // Cycle-by-cycle comparison of u0 against the model
    always @(negedge clk) begin
        if (rst0) begin
            check("u0_cycle",
                  {20'd0, sd0, bz0, if0.out_valid, if0.overrun, if0.pOut},
                  {20'd0, m_start, m_busy, m_valid, m_ovr, m_pout});
            check("u0_ferr", {31'd0, if0.frame_err}, 32'd0);
        end
    end

    task automatic send(input int which, input logic [31:0] v,
                        input int n);
        for (int i = n - 1; i >= 0; i--) begin
            case (which)
                0: sIn0 = v[i];
                1: sIn1 = v[i];
                default: sIn2 = v[i];
            endcase
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [31:0] bits;
        int          n;
        logic        rdy;
        logic        exp_valid;
        logic [7:0]  exp_pout;
        int          exp_st;
        int          exp_ov;
        int          exp_busy;
    } vec_t;

    vec_t tbl[9];
    int   s_st, s_ov, s_bc, s_fe;
    logic [7:0] rw;

    initial begin
        tbl[0] = '{32'h0000F0A5, 16, 1'b0, 1'b1, 8'hA5, 1, 0, 8};
        tbl[1] = '{32'h0000103C, 16, 1'b1, 1'b1, 8'h3C, 1, 0, 8};
        tbl[2] = '{32'h0000000F,  4, 1'b1, 1'b0, 8'h3C, 0, 0, 0};
        tbl[3] = '{32'h00011022, 24, 1'b0, 1'b1, 8'h11, 2, 1, 16};
        tbl[4] = '{32'h00000001,  1, 1'b1, 1'b0, 8'h11, 0, 0, 0};
        tbl[5] = '{32'h00000011, 12, 1'b0, 1'b1, 8'h11, 1, 0, 8};
        tbl[6] = '{32'h0000003B, 11, 1'b0, 1'b1, 8'h11, 1, 0, 8};
        tbl[7] = '{32'h00000001,  1, 1'b1, 1'b1, 8'h77, 0, 0, 0};
        tbl[8] = '{32'h00000001,  1, 1'b1, 1'b0, 8'h77, 0, 0, 0};

        sIn0 = 1'b1; sIn1 = 1'b1; sIn2 = 1'b1;
        if0.out_ready = 1'b0;
        if1.out_ready = 1'b0;
        if2.out_ready = 1'b0;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_u0", {20'd0, sd0, bz0, if0.out_valid, if0.overrun,
                         if0.pOut}, 32'd0);
        check("rst_u1", {22'd0, if1.frame_err, if1.out_valid, if1.pOut},
              32'd0);
        check("rst_u2", {18'd0, sd2, bz2, if2.out_valid, if2.pOut}, 32'd0);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        @(negedge clk);

        // Directed table on the default configuration
        for (int k = 0; k < 9; k++) begin
            s_st = st0; s_ov = ov0; s_bc = bc0;
            if0.out_ready = tbl[k].rdy;
            send(0, tbl[k].bits, tbl[k].n);
            #1;
            check($sformatf("t%0d_valid", k), {31'd0, if0.out_valid},
                  {31'd0, tbl[k].exp_valid});
            check($sformatf("t%0d_pout", k), {24'd0, if0.pOut},
                  {24'd0, tbl[k].exp_pout});
            check($sformatf("t%0d_start", k), st0 - s_st, tbl[k].exp_st);
            check($sformatf("t%0d_ovr", k), ov0 - s_ov, tbl[k].exp_ov);
            check($sformatf("t%0d_busy", k), bc0 - s_bc, tbl[k].exp_busy);
        end
        if0.out_ready = 1'b0;
        sIn0 = 1'b1;

        // Parity enabled: good parity, then bad parity
        s_fe = fe1; s_bc = bc1;
        send(1, 32'h003, 12);
        send(1, 32'h0, 1);
        #1;
        check("par_ok_valid", {31'd0, if1.out_valid}, 32'd1);
        check("par_ok_pout", {24'd0, if1.pOut}, 32'h03);
        check("par_ok_busy", bc1 - s_bc, 9);
        check("par_ok_ferr", fe1 - s_fe, 0);
        if1.out_ready = 1'b1;
        send(1, 32'h1, 1);
        #1;
        check("par_consume", {31'd0, if1.out_valid}, 32'd0);
        if1.out_ready = 1'b0;
        s_fe = fe1;
        send(1, 32'h003, 12);
        send(1, 32'h1, 1);
        #1;
        check("par_bad_pulse", {31'd0, if1.frame_err}, 32'd1);
        check("par_bad_valid", {31'd0, if1.out_valid}, 32'd0);
        sIn1 = 1'b1;
        send(1, 32'h1, 1);
        #1;
        check("par_bad_count", fe1 - s_fe, 1);

        // Wide configuration: reset mid-payload with a word pending
        send(2, 32'b101100, 6);
        send(2, 32'h123, 12);
        #1;
        check("w_first_valid", {31'd0, if2.out_valid}, 32'd1);
        check("w_first_pout", {20'd0, if2.pOut}, 32'h123);
        send(2, 32'b101100, 6);
        send(2, 32'b10101, 5);
        #1;
        check("w_mid_busy", {31'd0, bz2}, 32'd1);
        rst2 = 1'b0;
        #1;
        check("w_rst_outs", {14'd0, sd2, bz2, if2.out_valid, if2.overrun,
                             if2.frame_err, 1'b0, if2.pOut}, 32'd0);
        @(negedge clk);
        rst2 = 1'b1;
        sIn2 = 1'b1;
        @(negedge clk);
        send(2, 32'b101100, 6);
        send(2, 32'hABC, 12);
        #1;
        check("w_abc_valid", {31'd0, if2.out_valid}, 32'd1);
        check("w_abc_pout", {20'd0, if2.pOut}, 32'hABC);

        // Randomized frames with random ready on the default configuration
        for (int f = 0; f < 200; f++) begin
            int idle;
            idle = $urandom_range(0, 3);
            for (int i = 0; i < idle; i++) begin
                if0.out_ready = 1'($urandom_range(0, 1));
                sIn0 = (f % 7 == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
            end
            for (int i = 0; i < 4; i++) begin
                if0.out_ready = 1'($urandom_range(0, 1));
                sIn0 = 1'b0;
                @(negedge clk);
            end
            rw = 8'($urandom);
            for (int i = 7; i >= 0; i--) begin
                if0.out_ready = 1'($urandom_range(0, 1));
                sIn0 = rw[i];
                @(negedge clk);
            end
        end
        if0.out_ready = 1'b1;
        sIn0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
